noc_flit_injector: RTL and testbench

NOC_FLIT_INJECTOR -- requirements
Module: noc_flit_injector

---
 rtl/noc_flit_injector.sv | 127 ++++++++++++
 tb/tb_noc_flit_injector.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_flit_injector.sv
// Local-port flit injector: queues upstream requests in a small FIFO and streams
// them into the router local input as 8-bit flits. Optional counters: NOC_INJ_STATS_EN.
module noc_flit_injector #(
    parameter int         DEPTH  = 4,
    parameter logic [2:0] SRC_ID = 3'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [2:0]               req_dest,
    input  logic [3:0]               req_data,
    output logic                     req_ready,
    input  logic                     Full,
    output logic [7:0]               flit_out,
    output logic                     Write,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [1:0]               state,
    output logic [7:0]               inj_count,
    output logic [7:0]               drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    logic [6:0]    mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [OW-1:0] occ_reg;
    logic [OW-1:0] occ_next;
    logic [7:0]    flit_reg;
    logic          write_reg;
    state_t        state_reg;

    logic accept;
    logic push;
    logic pop;

    // Ready depends only on the stored count, never on a same-cycle pop.
    assign req_ready = (occ_reg != OW'(DEPTH));
    assign accept    = req_valid && req_ready;
    assign push      = accept && (req_dest != SRC_ID);
    assign pop       = (occ_reg != '0) && !Full;
    assign occ_next  = occ_reg + OW'(push) - OW'(pop);

    // Storage has no reset so it maps onto RAM; stale entries are unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= {req_data, req_dest};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            flit_reg   <= 8'h00;
            write_reg  <= 1'b0;
            state_reg  <= IDLE;
        end else begin
            occ_reg <= occ_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
                flit_reg   <= {1'b1, mem_reg[rd_ptr_reg]};
                write_reg  <= 1'b1;
            end else begin
                flit_reg   <= 8'h00;
                write_reg  <= 1'b0;
            end
            // Transitions look at the post-edge count and the current Full.
            if (occ_next == '0) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE:    state_reg <= ACTIVE;
                    ACTIVE:  if (Full)  state_reg <= BLOCKED;
                    BLOCKED: if (!Full) state_reg <= ACTIVE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign flit_out  = flit_reg;
    assign Write     = write_reg;
    assign occupancy = occ_reg;
    assign state     = state_reg;

`ifdef NOC_INJ_STATS_EN
    logic [7:0] inj_count_reg;
    logic [7:0] drop_count_reg;
    logic       drop;

    assign drop = accept && (req_dest == SRC_ID);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_count_reg  <= 8'h00;
            drop_count_reg <= 8'h00;
        end else begin
            // inj_count rises on the same edge that raises Write.
            if (pop && inj_count_reg != 8'hFF) begin
                inj_count_reg <= inj_count_reg + 8'd1;
            end
            if (drop && drop_count_reg != 8'hFF) begin
                drop_count_reg <= drop_count_reg + 8'd1;
            end
        end
    end

    assign inj_count  = inj_count_reg;
    assign drop_count = drop_count_reg;
`else
    assign inj_count  = 8'h00;
    assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_noc_flit_injector.sv
// Directed bench for noc_flit_injector (DEPTH=4, SRC_ID=0): vector table plus
// hand-written sequences for streaming, reset flush and counter saturation.
module tb_noc_flit_injector;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic [2:0] req_dest;
    logic [3:0] req_data;
    logic       req_ready;
    logic       Full;
    logic [7:0] flit_out;
    logic       Write;
    logic [2:0] occupancy;
    logic [1:0] state;
    logic [7:0] inj_count;
    logic [7:0] drop_count;

    int n_cmp;
    int n_err;

    noc_flit_injector #(.DEPTH(4), .SRC_ID(3'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_dest   (req_dest),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .Full       (Full),
        .flit_out   (flit_out),
        .Write      (Write),
        .occupancy  (occupancy),
        .state      (state),
        .inj_count  (inj_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [2:0] d;
        logic [3:0] dat;
        logic       f;
        logic [7:0] ef;
        logic       ew;
        logic [2:0] eo;
        logic [1:0] es;
        logic       er;
    } vec_t;

    vec_t vecs [19];

`ifdef NOC_INJ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] d, input logic [3:0] dat, input logic f);
        req_valid = v;
        req_dest  = d;
        req_data  = dat;
        Full      = f;
    endtask

    logic [6:0] q [$];
    logic [6:0] head;
    logic [7:0] exp_inj;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 1'b0);

        //              v     d     dat    f     flit   W     occ   st    rdy
        vecs[0]  = '{1'b1, 3'd1, 4'hA, 1'b0, 8'h00, 1'b0, 3'd1, 2'd1, 1'b1};
        vecs[1]  = '{1'b0, 3'd0, 4'h0, 1'b0, 8'hD1, 1'b1, 3'd0, 2'd0, 1'b1};
        vecs[2]  = '{1'b0, 3'd0, 4'h0, 1'b0, 8'h00, 1'b0, 3'd0, 2'd0, 1'b1};
        vecs[3]  = '{1'b1, 3'd0, 4'h5, 1'b0, 8'h00, 1'b0, 3'd0, 2'd0, 1'b1};
        vecs[4]  = '{1'b0, 3'd0, 4'h0, 1'b0, 8'h00, 1'b0, 3'd0, 2'd0, 1'b1};
        vecs[5]  = '{1'b1, 3'd1, 4'h1, 1'b1, 8'h00, 1'b0, 3'd1, 2'd1, 1'b1};
        vecs[6]  = '{1'b1, 3'd2, 4'h2, 1'b1, 8'h00, 1'b0, 3'd2, 2'd2, 1'b1};
        vecs[7]  = '{1'b1, 3'd3, 4'h3, 1'b1, 8'h00, 1'b0, 3'd3, 2'd2, 1'b1};
        vecs[8]  = '{1'b1, 3'd4, 4'h4, 1'b1, 8'h00, 1'b0, 3'd4, 2'd2, 1'b0};
        vecs[9]  = '{1'b1, 3'd5, 4'h5, 1'b1, 8'h00, 1'b0, 3'd4, 2'd2, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 4'h0, 1'b0, 8'h89, 1'b1, 3'd3, 2'd1, 1'b1};
        vecs[11] = '{1'b0, 3'd0, 4'h0, 1'b0, 8'h92, 1'b1, 3'd2, 2'd1, 1'b1};
        vecs[12] = '{1'b0, 3'd0, 4'h0, 1'b0, 8'h9B, 1'b1, 3'd1, 2'd1, 1'b1};
        vecs[13] = '{1'b0, 3'd0, 4'h0, 1'b0, 8'hA4, 1'b1, 3'd0, 2'd0, 1'b1};
        vecs[14] = '{1'b0, 3'd0, 4'h0, 1'b0, 8'h00, 1'b0, 3'd0, 2'd0, 1'b1};
        vecs[15] = '{1'b1, 3'd6, 4'h7, 1'b0, 8'h00, 1'b0, 3'd1, 2'd1, 1'b1};
        vecs[16] = '{1'b1, 3'd7, 4'h8, 1'b0, 8'hBE, 1'b1, 3'd1, 2'd1, 1'b1};
        vecs[17] = '{1'b0, 3'd0, 4'h0, 1'b1, 8'h00, 1'b0, 3'd1, 2'd2, 1'b1};
        vecs[18] = '{1'b0, 3'd0, 4'h0, 1'b0, 8'hC7, 1'b1, 3'd0, 2'd0, 1'b1};

        // Reset state, with an edge passing while held in reset.
        #12;
        check("rst flit", 32'(flit_out), 32'h00);
        check("rst write", 32'(Write), 32'h0);
        check("rst occ", 32'(occupancy), 32'h0);
        check("rst state", 32'(state), 32'h0);
        check("rst ready", 32'(req_ready), 32'h1);
        check("rst inj", 32'(inj_count), 32'h00);
        check("rst drop", 32'(drop_count), 32'h00);
        rst = 1'b1;

        exp_inj = 8'h00;
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].dat, vecs[i].f);
            step();
            $display("vec %0d: v=%0b d=%0d dat=%0h full=%0b -> flit=%02h W=%0b occ=%0d st=%0d rdy=%0b",
                     i, vecs[i].v, vecs[i].d, vecs[i].dat, vecs[i].f,
                     flit_out, Write, occupancy, state, req_ready);
            check($sformatf("vec%0d flit", i), 32'(flit_out), 32'(vecs[i].ef));
            check($sformatf("vec%0d write", i), 32'(Write), 32'(vecs[i].ew));
            check($sformatf("vec%0d occ", i), 32'(occupancy), 32'(vecs[i].eo));
            check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].es));
            check($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].er));
            if (vecs[i].ew) exp_inj++;
        end
        check("tbl inj", 32'(inj_count), STATS ? 32'(exp_inj) : 32'h00);
        check("tbl drop", 32'(drop_count), STATS ? 32'h01 : 32'h00);

        // Continuous push and pop: occupancy holds at 1 while pointers wrap.
        q.delete();
        drive(1'b1, 3'd1, 4'h0, 1'b0);
        q.push_back({4'h0, 3'd1});
        step();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 3'((i % 7) + 1), 4'(i), 1'b0);
            q.push_back({4'(i), 3'((i % 7) + 1)});
            step();
            head = q.pop_front();
            $display("stream %0d: flit=%02h W=%0b occ=%0d", i, flit_out, Write, occupancy);
            check($sformatf("stream%0d flit", i), 32'(flit_out), 32'({1'b1, head}));
            check($sformatf("stream%0d occ", i), 32'(occupancy), 32'd1);
        end
        drive(1'b0, 3'd0, 4'h0, 1'b0);
        step();
        head = q.pop_front();
        $display("stream drain: flit=%02h W=%0b occ=%0d", flit_out, Write, occupancy);
        check("stream drain flit", 32'(flit_out), 32'({1'b1, head}));
        check("stream drain occ", 32'(occupancy), 32'd0);

        // Reset with three entries queued and Write high.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i + 1), 4'(i + 3), 1'b1);
            step();
        end
        drive(1'b0, 3'd0, 4'h0, 1'b0);
        step();
        check("pre-rst write", 32'(Write), 32'h1);
        check("pre-rst occ", 32'(occupancy), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        $display("async reset: flit=%02h W=%0b occ=%0d st=%0d rdy=%0b", flit_out, Write, occupancy, state, req_ready);
        check("arst occ", 32'(occupancy), 32'd0);
        check("arst write", 32'(Write), 32'h0);
        check("arst flit", 32'(flit_out), 32'h00);
        check("arst state", 32'(state), 32'h0);
        check("arst ready", 32'(req_ready), 32'h1);
        check("arst inj", 32'(inj_count), 32'h00);
        drive(1'b1, 3'd2, 4'h6, 1'b0);
        step();
        check("in-rst no accept", 32'(occupancy), 32'd0);
        drive(1'b0, 3'd0, 4'h0, 1'b0);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            $display("post-rst %0d: flit=%02h W=%0b occ=%0d", i, flit_out, Write, occupancy);
            check($sformatf("post-rst%0d write", i), 32'(Write), 32'h0);
            check($sformatf("post-rst%0d flit", i), 32'(flit_out), 32'h00);
        end

        // 300 non-self requests drive inj_count into saturation.
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 3'd2, 4'(i), 1'b0);
            step();
        end
        drive(1'b0, 3'd0, 4'h0, 1'b0);
        step();
        step();
        $display("saturation: inj=%02h drop=%02h occ=%0d", inj_count, drop_count, occupancy);
        check("sat inj", 32'(inj_count), STATS ? 32'hFF : 32'h00);
        check("sat drop", 32'(drop_count), 32'h00);
        check("sat occ", 32'(occupancy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
